// File: rtl/pe_grid_pkg.sv
// Shared types and arithmetic helpers for the row-stationary PE grid.
// Compile-time option: PE_SAT_EN (saturating accumulate and reduce).
// When PE_SAT_EN is undefined every add wraps modulo 2^w.
package pe_grid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        HOLD   = 2'd2
    } grid_state_e;

    localparam int DEF_ROWS = 12;
    localparam int DEF_COLS = 14;
    localparam int DEF_DW   = 16;
    localparam int DEF_FRAC = 8;
    localparam int DEF_PW   = 32;

    // Adds two sign-extended operands and folds the result back into a
    // w-bit signed range (1 <= w <= 64). Callers size-cast the result to w
    // bits, so the upper bits are just the sign extension.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] s;
`ifdef PE_SAT_EN
        logic signed [64:0] hi;
        logic signed [64:0] lo;
`endif
        s = {a[63], a} + {b[63], b};
`ifdef PE_SAT_EN
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
`else
        // Pure wiring once w is a constant: re-sign-extend from bit w-1.
        s = (s <<< (65 - w)) >>> (65 - w);
`endif
        return s[63:0];
    endfunction

endpackage

// File: rtl/pe_cell.sv
// One processing element: a weight register and a Q-format accumulator.
// Compile-time option: PE_SAT_EN (saturating accumulate, via sat_add).
// All enables arrive pre-gated by the grid; the cell applies them blindly.
module pe_cell
    import pe_grid_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int FRAC = DEF_FRAC,
    parameter int PW   = DEF_PW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic signed [DW-1:0] i_wval,
    input  logic                 i_fire,
    input  logic signed [DW-1:0] i_xval,
    input  logic                 i_clr,
    output logic signed [PW-1:0] o_acc
);

    logic signed [DW-1:0]   r_w;
    logic signed [PW-1:0]   r_acc;
    logic signed [2*DW-1:0] w_prod;
    logic signed [2*DW-1:0] w_prod_sh;
    logic signed [63:0]     w_base64;
    logic signed [63:0]     w_prod64;
    logic signed [PW-1:0]   w_acc_sum;

    // The product always uses the registered weight, so a weight load in the
    // same cycle as a fire only affects later fires.
    assign w_prod    = r_w * i_xval;
    assign w_prod_sh = w_prod >>> FRAC;
    assign w_prod64  = w_prod_sh;
    // Clear-then-add: a clear coinciding with a fire leaves just the product.
    assign w_base64  = i_clr ? 64'sd0 : r_acc;
    assign w_acc_sum = PW'(sat_add(w_base64, w_prod64, PW));
    assign o_acc     = r_acc;

    // Weight load and accumulate/clear update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_w   <= '0;
            r_acc <= '0;
        end else begin
            if (i_load) begin
                r_w <= i_wval;
            end
            if (i_fire) begin
                r_acc <= w_acc_sum;
            end else if (i_clr) begin
                r_acc <= '0;
            end
        end
    end

endmodule

// File: rtl/pe_grid_rs.sv
// Parametrised row-stationary PE grid with tagged weight/ifmap delivery and a
// column-reduction read-out using a valid/ready handshake.
// Compile-time option: PE_SAT_EN (saturating accumulate and reduce adds).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accepts weight loads, ifmap fires, acc_clr and rd_req
//   REDUCE | adds PE row r_idx into col_sum each cycle, PEs frozen
//   HOLD   | out_valid high, psum_outs = col_sum, wait for out_ready
module pe_grid_rs
    import pe_grid_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int FRAC = DEF_FRAC,
    parameter int PW   = DEF_PW,
    parameter int TW   = $clog2(ROWS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic signed [DW-1:0] i_row_weight_vals [COLS],
    input  logic [TW-1:0]        i_tag_row,
    input  logic                 i_valid_y,
    input  logic signed [DW-1:0] i_image_val_vec [COLS],
    input  logic [COLS-1:0]      i_valid_x_vec,
    input  logic [TW-1:0]        i_tag_x,
    input  logic                 i_x_bcast,
    input  logic                 i_acc_clr,
    input  logic                 i_rd_req,
    input  logic signed [PW-1:0] i_psum_ins [COLS],
    output logic signed [PW-1:0] o_psum_outs [COLS],
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_busy
);

    grid_state_e          r_state;
    logic [TW-1:0]        r_idx;
    logic signed [PW-1:0] r_col_sum [COLS];
    logic                 r_out_valid;
    logic                 r_busy;

    logic                 w_idle;
    logic                 w_clr;
    logic                 w_load [ROWS];
    logic                 w_fire [ROWS][COLS];
    logic signed [PW-1:0] w_acc [ROWS][COLS];
    logic signed [PW-1:0] w_col_next [COLS];

    // Every PE-side strobe is qualified by IDLE so the array is frozen while
    // a reduction is in flight.
    assign w_idle = (r_state == IDLE);
    assign w_clr  = w_idle & i_acc_clr;

    // Tag decode and the PE array. Out-of-range tags match no row, which
    // makes them silent no-ops.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        assign w_load[gr] = w_idle & i_valid_y & (i_tag_row == TW'(gr));
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            assign w_fire[gr][gc] = w_idle & i_valid_x_vec[gc]
                                    & (i_x_bcast | (i_tag_x == TW'(gr)));
            pe_cell #(
                .DW   (DW),
                .FRAC (FRAC),
                .PW   (PW)
            ) u_pe (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_load (w_load[gr]),
                .i_wval (i_row_weight_vals[gc]),
                .i_fire (w_fire[gr][gc]),
                .i_xval (i_image_val_vec[gc]),
                .i_clr  (w_clr),
                .o_acc  (w_acc[gr][gc])
            );
        end
    end

    // One adder per column: running column sum plus the selected row.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_red
        logic signed [63:0] w_a64;
        logic signed [63:0] w_b64;
        assign w_a64          = r_col_sum[gc];
        assign w_b64          = w_acc[r_idx][gc];
        assign w_col_next[gc] = PW'(sat_add(w_a64, w_b64, PW));
    end

    // Read-out FSM with registered valid/busy; col_sum doubles as psum_outs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                r_col_sum[c] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_rd_req) begin
                        for (int c = 0; c < COLS; c++) begin
                            r_col_sum[c] <= i_psum_ins[c];
                        end
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= REDUCE;
                    end
                end
                REDUCE: begin
                    for (int c = 0; c < COLS; c++) begin
                        r_col_sum[c] <= w_col_next[c];
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == TW'(ROWS - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_psum_outs = r_col_sum;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;

endmodule

// File: doc/pe_grid_rs.md
# pe_grid_rs

Parametrised row-stationary PE grid: the successor to the fixed 12x14 grid. Filter rows load into PE rows by tag. Ifmap values multicast to one tagged row or broadcast to all rows. Each PE keeps a Q-format accumulator across injections. A read-out FSM reduces the accumulators down each column into a held `psum_outs` vector with a valid/ready handshake. The block sits between the global buffer / NoC and the psum writeback path.

## Interface
- `ROWS`, 12, PE rows.
- `COLS`, 14, PE columns.
- `DW`, 16, signed weight/ifmap width (Q7.8 at default).
- `FRAC`, 8, fractional bits dropped after multiply.
- `PW`, 32, signed psum/accumulator width.
- `TW`, `$clog2(ROWS)`, tag width.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `row_weight_vals[COLS]`  in  DW  weight per column.
- `tag_row`  in  TW  target PE row for the weight load.
- `valid_y`  in  1  weight load strobe.
- `image_val_vec[COLS]`  in  DW  ifmap value per column.
- `valid_x_vec[COLS]`  in  1  per-column ifmap strobe.
- `tag_x`  in  TW  target PE row for the ifmap.
- `x_bcast`  in  1  1 = ifmap goes to all rows; `tag_x` is ignored.
- `acc_clr`  in  1  clears all accumulators.
- `rd_req`  in  1  starts column reduction.
- `psum_ins[COLS]`  in  PW  reduction seed per column, sampled on `rd_req` acceptance.
- `psum_outs[COLS]`  out  PW  reduced column sums.
- `out_valid`  out  1  `psum_outs` valid.
- `out_ready`  in  1  consumer accepts `psum_outs`.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, REDUCE, HOLD. Reset value is IDLE.
- **Weight load.** Applies in IDLE with `valid_y` and `tag_row < ROWS`. PE(`tag_row`, c).w <= `row_weight_vals[c]` for every c. A `tag_row` >= ROWS is a silent no-op.
- **Ifmap fire.** Applies in IDLE with `valid_x_vec[c]`. The target is PE(r, c) for all r when `x_bcast`, else r == `tag_x`. The PE computes acc <= acc + sext_PW((w * x) >>> FRAC), using a 2*DW signed product and an arithmetic shift. An out-of-range `tag_x` with `x_bcast`=0 is a no-op.
- **Same-cycle weight load and ifmap fire on one PE.** The product uses the old weight.
- **`acc_clr`.** Acts in IDLE only. If it coincides with a fire, acc <= the new product alone (clear, then add).
- **Read start.** `rd_req` in IDLE: col_sum[c] <= `psum_ins[c]`, r_idx <= 0, go to REDUCE.
- **REDUCE.** Each cycle col_sum[c] <= col_sum[c] + acc[r_idx][c] and r_idx increments. After r_idx == ROWS-1, go to HOLD.
- **HOLD.** `out_valid`=1 and `psum_outs` equal col_sum, held stable. On `out_valid && out_ready` go to IDLE. Accumulators are not auto-cleared.
- **Inputs while not IDLE.** `valid_y`, `valid_x_vec`, `acc_clr` and `rd_req` are ignored; accumulators are frozen. Upstream must watch `busy`.
- **Default overflow.** Wraps modulo 2^PW.

## Timing
- Weight and accumulator updates take effect at the next edge; the product is visible in acc 1 cycle after the fire.
- `rd_req` sampled at edge E0 gives `out_valid` high after edge E0+ROWS. With ROWS=12 that is 12 cycles.
- `busy` rises after E0 and falls after the handshake edge.
- A new `rd_req` is accepted no earlier than the cycle after the handshake.
- A zero-wait consumer (`out_ready` tied 1) sees `out_valid` for exactly one cycle.
- **Reset values.** `psum_outs`=0, `out_valid`=0, `busy`=0, all w/acc/col_sum=0, state IDLE.
- **Reset asserted mid-REDUCE or mid-HOLD.** Immediately returns all of the above to their reset values, with no handshake completion.

## Configuration
- `PE_SAT_EN` defined: each PE accumulate and each REDUCE add saturates to [-2^(PW-1), 2^(PW-1)-1].
- `PE_SAT_EN` undefined: two's-complement wrap. No extra logic is generated.

## Structure
- **`pe_grid_pkg`** contains:
  - the state enum (IDLE/REDUCE/HOLD);
  - default constants ROWS/COLS/DW/FRAC/PW;
  - a `sat_add` function gated by `PE_SAT_EN`.
- **Sub-module `pe_cell`** contains:
  - the weight register and accumulator;
  - the multiply/shift/add logic;
  - fire and load enables.

  It is instantiated ROWS x COLS. The top level holds tag decode, FSM, r_idx and col_sum.

## Test plan
- **Weight/ifmap row load and reduce.**
  - Stimulus: row 0 weights 0x0100, row 1 weights 0x0200 (all cols), other rows 0; broadcast ifmap 0x0100 on all cols; `rd_req` with `psum_ins`=0.
  - Response: `out_valid` exactly 12 cycles after acceptance; every `psum_outs[c]`=0x00000300.
- **Tagged ifmap.**
  - Stimulus: weights 0x0100 everywhere; ifmap 0x0080 with `tag_x`=3 and `x_bcast`=0; then `tag_x`=13.
  - Response: only row 3 accumulates; the sum is 0x00000080 per column; the tag-13 fire has no effect.
- **Seed, backpressure and busy gating.**
  - Stimulus: `psum_ins[c]`=c; `out_ready` held low 5 cycles after `out_valid`; `valid_y`/`valid_x_vec` pulsed during HOLD.
  - Response: `psum_outs[c]`=sum+c held stable; `busy`=1 throughout; weights and accumulators unchanged.
- **`acc_clr` coinciding with a fire.**
  - Stimulus: accumulators preloaded to 0x300; `acc_clr` and an ifmap fire (w=0x0100, x=0x0200) in the same cycle.
  - Response: the next reduction gives 0x00000200.
- **Overflow.**
  - Stimulus: w=x=0x7FFF on row 0 only (product 0x003FFF00); `psum_ins`=0x7FFFFF00.
  - Response: with `PE_SAT_EN`, `psum_outs`=0x7FFFFFFF; without it, `psum_outs`=0x803FFE00.
- **Reset mid-REDUCE.**
  - Stimulus: `rst` asserted in the 4th REDUCE cycle.
  - Response: `out_valid`=0, `busy`=0, `psum_outs`=0 immediately; a following reduction returns 0 in all columns.
